uart_tx_queue: RTL

Transmit-side buffer and serializer downstream of the CPU core's RS-232C send path. It accepts bytes on the core's `tx_send_enable`/`tx_send_data` pulse interface and queues them in a FIFO. It then shifts them out on the serial line as 8N1 frames, so `send` instructions never stall on line speed.

---
 rtl/uart_tx_queue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding an 8N1 serializer: the core pushes bytes at full speed and the
// serializer drains them onto txd at line rate.
module uart_tx_queue #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned CLKS_PER_BIT = 573
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_enable,
  input  logic [7:0]            push_data,
  output logic                  txd,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push_ok;
  logic                  pop;

  state_t                state;
  state_t                state_nxt;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BAUD_W-1:0]     baud_nxt;
  logic [2:0]            bit_idx;
  logic [2:0]            bit_nxt;
  logic [7:0]            shift;
  logic [7:0]            shift_nxt;
  logic                  txd_nxt;
  logic                  baud_done;

  // A full queue drops the push even when a pop frees a slot in the same cycle.
  assign push_ok   = push_enable & ~full;
  assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array needs no reset: pointers and count gate what is ever read.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
      if (push_enable && full) overflow <= 1'b1;
    end
  end

  // Serializer next-state; a frame ending with data queued chains straight into START.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + BAUD_W'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        baud_nxt  = '0;
        state_nxt = S_IDLE;
      end
    endcase

    case (state_nxt)
      S_START: txd_nxt = 1'b0;
      S_DATA:  txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      txd      <= txd_nxt;
      busy     <= (state_nxt != S_IDLE);
    end
  end

endmodule
